// File: rtl/multicycle_control.sv
// Multicycle control FSM for the RV64 datapath: sequences fetch/decode/exec/mem/wb.
// Ports: clock, reset, run, opcode, flag in; datapath enables, mux selects, busy, instr_done, illegal, instret, state out.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             flag,
  output logic             wePC,
  output logic             weIR,
  output logic             weReg,
  output logic             weMem,
  output logic             sinalMux1,
  output logic [1:0]       sinalMux2,
  output logic             sinalMux4,
  output logic             busy,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t           state_q;
  logic [6:0]       opcode_q;
  logic             we_pc_q;
  logic             we_ir_q;
  logic             we_reg_q;
  logic             we_mem_q;
  logic             mux1_q;
  logic [1:0]       mux2_q;
  logic             mux4_q;
  logic             busy_q;
  logic             illegal_q;
  logic [CNT_W-1:0] instret_q;

  // flag drives next-PC selection in the datapath only
  logic unused_flag;
  assign unused_flag = flag;

  // returns {known, mux1, mux2, mux4}
  function automatic logic [4:0] decode_sel(input logic [6:0] op);
    logic [4:0] r;
    r = 5'b0;
    case (op)
      OP_OP:     r = {1'b1, 1'b1, 2'd1, 1'b0};
      OP_IMM:    r = {1'b1, 1'b0, 2'd1, 1'b0};
      OP_LOAD:   r = {1'b1, 1'b0, 2'd0, 1'b0};
      OP_STORE:  r = {1'b1, 1'b0, 2'd0, 1'b0};
      OP_BRANCH: r = {1'b1, 1'b1, 2'd0, 1'b0};
      OP_AUIPC:  r = {1'b1, 1'b0, 2'd3, 1'b0};
      OP_JAL:    r = {1'b1, 1'b0, 2'd2, 1'b0};
      OP_JALR:   r = {1'b1, 1'b0, 2'd2, 1'b1};
      default:   r = 5'b0;
    endcase
    return r;
  endfunction

  logic [4:0] dec;
  assign dec = decode_sel(opcode);

  // Outputs are registered from the next state; write enables are
  // additionally masked so a reset cycle never commits a write.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      opcode_q  <= 7'd0;
      we_pc_q   <= 1'b0;
      we_ir_q   <= 1'b0;
      we_reg_q  <= 1'b0;
      we_mem_q  <= 1'b0;
      mux1_q    <= 1'b0;
      mux2_q    <= 2'd0;
      mux4_q    <= 1'b0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      we_pc_q  <= 1'b0;
      we_ir_q  <= 1'b0;
      we_reg_q <= 1'b0;
      we_mem_q <= 1'b0;
      if (we_pc_q) instret_q <= instret_q + CNT_W'(1);
      unique case (state_q)
        IDLE: begin
          if (run) begin
            state_q <= FETCH;
            we_ir_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        FETCH: state_q <= DECODE;
        DECODE: begin
          opcode_q <= opcode;
          if (dec[4]) begin
            state_q <= EXEC;
            mux1_q  <= dec[3];
            mux2_q  <= dec[2:1];
            mux4_q  <= dec[0];
            we_pc_q <= (opcode == OP_BRANCH);
          end else begin
            state_q   <= HALT;
            illegal_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        EXEC: begin
          if (opcode_q == OP_BRANCH) begin
            state_q <= run ? FETCH : IDLE;
            we_ir_q <= run;
            busy_q  <= run;
            mux1_q  <= 1'b0;
            mux2_q  <= 2'd0;
            mux4_q  <= 1'b0;
          end else if (opcode_q == OP_LOAD) begin
            state_q <= MEM;
          end else if (opcode_q == OP_STORE) begin
            state_q  <= MEM;
            we_mem_q <= 1'b1;
            we_pc_q  <= 1'b1;
          end else begin
            state_q  <= WB;
            we_reg_q <= 1'b1;
            we_pc_q  <= 1'b1;
          end
        end
        MEM: begin
          if (opcode_q == OP_LOAD) begin
            state_q  <= WB;
            we_reg_q <= 1'b1;
            we_pc_q  <= 1'b1;
          end else begin
            state_q <= run ? FETCH : IDLE;
            we_ir_q <= run;
            busy_q  <= run;
            mux1_q  <= 1'b0;
            mux2_q  <= 2'd0;
            mux4_q  <= 1'b0;
          end
        end
        WB: begin
          state_q <= run ? FETCH : IDLE;
          we_ir_q <= run;
          busy_q  <= run;
          mux1_q  <= 1'b0;
          mux2_q  <= 2'd0;
          mux4_q  <= 1'b0;
        end
        HALT: state_q <= HALT;
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wePC       = we_pc_q & ~reset;
  assign weIR       = we_ir_q & ~reset;
  assign weReg      = we_reg_q & ~reset;
  assign weMem      = we_mem_q & ~reset;
  assign instr_done = wePC;
  assign sinalMux1  = mux1_q;
  assign sinalMux2  = mux2_q;
  assign sinalMux4  = mux4_q;
  assign busy       = busy_q;
  assign illegal    = illegal_q;
  assign instret    = instret_q;
  assign state      = state_q;

endmodule
